// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, FSM encoding and default timing,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int   DATA_BITS     = 8;
  localparam logic START_BIT     = 1'b0;
  localparam logic STOP_BIT      = 1'b1;
  localparam int   DEF_CLK_FREQ  = 1000000;
  localparam int   DEF_BAUD_RATE = 9600;

  function automatic int calc_bit_cycles(input int clk_freq, input int baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Baud-rate clock enable: one-cycle tick every CLK_FREQ/BAUD_RATE clocks,
// restarted from zero whenever clear is high.
module uart_baud_gen import uart_pkg::*; #(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int BIT_CYCLES = calc_bit_cycles(CLK_FREQ, BAUD_RATE);
  localparam int CW         = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

  generate
    if (BIT_CYCLES < 2) begin : g_bad_cfg
      $error("uart_baud_gen: CLK_FREQ/BAUD_RATE must be at least 2");
    end
  endgenerate

  logic [CW-1:0] r_cnt;

  assign tick = (r_cnt == CW'(BIT_CYCLES - 1));

  // Free-running bit-period counter, wraps on tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= {CW{1'b0}};
    end else if (clear || tick) begin
      r_cnt <= {CW{1'b0}};
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register feeding an 8N1 shifter,
// back-to-back frames with no idle gap when a byte is already held.
module uart_tx import uart_pkg::*; #(
  parameter int CLK_FREQ  = DEF_CLK_FREQ,
  parameter int BAUD_RATE = DEF_BAUD_RATE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  uart_state_e          r_state, w_state_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_hold_data, w_hold_data_nxt;
  logic                 r_hold_full, w_hold_full_nxt;
  logic [2:0]           r_bit_idx, w_bit_idx_nxt;
  logic                 r_tx, w_tx_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 w_tick, w_clear, w_accept;

  // Counter is held at zero while idle so a new frame starts a full bit period
  assign w_clear  = (r_state == ST_IDLE);
  assign w_accept = tx_valid & ~r_hold_full;

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_baud_gen (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_shift     <= {DATA_BITS{1'b0}};
      r_hold_data <= {DATA_BITS{1'b0}};
      r_hold_full <= 1'b0;
      r_bit_idx   <= 3'd0;
      r_tx        <= STOP_BIT;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_hold_data <= w_hold_data_nxt;
      r_hold_full <= w_hold_full_nxt;
      r_bit_idx   <= w_bit_idx_nxt;
      r_tx        <= w_tx_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt     = r_state;
    w_shift_nxt     = r_shift;
    w_hold_data_nxt = r_hold_data;
    w_hold_full_nxt = r_hold_full;
    w_bit_idx_nxt   = r_bit_idx;
    w_tx_nxt        = r_tx;
    w_done_nxt      = 1'b0;

    if (w_accept) begin
      w_hold_full_nxt = 1'b1;
      w_hold_data_nxt = tx_data;
    end else begin
      w_hold_full_nxt = r_hold_full;
      w_hold_data_nxt = r_hold_data;
    end

    case (r_state)
      ST_IDLE: begin
        if (r_hold_full) begin
          w_state_nxt     = ST_START;
          w_shift_nxt     = r_hold_data;
          w_hold_full_nxt = 1'b0;
          w_tx_nxt        = START_BIT;
        end else begin
          w_state_nxt = ST_IDLE;
          w_tx_nxt    = STOP_BIT;
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_state_nxt   = ST_DATA;
          w_bit_idx_nxt = 3'd0;
          w_tx_nxt      = r_shift[0];
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_tick) begin
          if (r_bit_idx == 3'(DATA_BITS - 1)) begin
            w_state_nxt = ST_STOP;
            w_tx_nxt    = STOP_BIT;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
            w_shift_nxt   = r_shift >> 1;
            w_tx_nxt      = r_shift[1];
          end
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_done_nxt = 1'b1;
          if (r_hold_full) begin
            w_state_nxt     = ST_START;
            w_shift_nxt     = r_hold_data;
            w_hold_full_nxt = 1'b0;
            w_tx_nxt        = START_BIT;
          end else begin
            w_state_nxt = ST_IDLE;
            w_tx_nxt    = STOP_BIT;
          end
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_hold_full_nxt = 1'b0;
        w_tx_nxt        = STOP_BIT;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  assign tx       = r_tx;
  assign tx_ready = ~r_hold_full;
  assign busy     = r_busy;
  assign tx_done  = r_done;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default-rate and BIT_CYCLES=2 instances, with a
// sampling receiver model that checks every bit boundary and tx_done timing.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       v0, v1;
  logic [7:0] d0, d1;
  logic       rdy0, tx0, busy0, done0;
  logic       rdy1, tx1, busy1, done1;
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx u_dut (
    .clk(clk), .rst(rst), .tx_valid(v0), .tx_data(d0),
    .tx_ready(rdy0), .tx(tx0), .busy(busy0), .tx_done(done0)
  );

  uart_tx #(.CLK_FREQ(20), .BAUD_RATE(10)) u_dut_fast (
    .clk(clk), .rst(rst), .tx_valid(v1), .tx_data(d1),
    .tx_ready(rdy1), .tx(tx1), .busy(busy1), .tx_done(done1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic pin_tx(input int sel);
    return (sel == 0) ? tx0 : tx1;
  endfunction
  function automatic logic pin_ready(input int sel);
    return (sel == 0) ? rdy0 : rdy1;
  endfunction
  function automatic logic pin_busy(input int sel);
    return (sel == 0) ? busy0 : busy1;
  endfunction
  function automatic logic pin_done(input int sel);
    return (sel == 0) ? done0 : done1;
  endfunction

  task automatic drive(input int sel, input logic v, input logic [7:0] d);
    if (sel == 0) begin v0 = v; d0 = d; end
    else begin v1 = v; d1 = d; end
  endtask

  // Offer a byte and wait for the accepting edge; data is scrambled afterwards
  task automatic send(input int sel, input logic [7:0] b, input bit keep_valid);
    logic r;
    int   n = 0;
    drive(sel, 1'b1, b);
    do begin
      r = pin_ready(sel);
      @(negedge clk);
      n++;
    end while (!r && n < 5000);
    if (!r) check_eq("accept_timeout", 32'd0, 32'd1);
    drive(sel, keep_valid, ~b);
  endtask

  task automatic wait_fall(input int sel, output int waits);
    waits = 0;
    while (pin_tx(sel) !== 1'b0 && waits < 3000) begin
      @(negedge clk);
      waits++;
    end
    if (waits >= 3000) check_eq("fall_timeout", 32'd0, 32'd1);
  endtask

  // Receiver model: checks first and last cycle of every bit, busy, and tx_done
  task automatic check_frame(input int sel, input logic [7:0] exp, input int bc, output int waits);
    logic [9:0] bits;
    bits = {1'b1, exp, 1'b0};
    wait_fall(sel, waits);
    if (waits >= 3000) return;
    for (int i = 0; i < 10 * bc; i++) begin
      if ((i % bc) == 0 || (i % bc) == bc - 1)
        check_eq($sformatf("s%0d_%02h_bit%0d_at%0d", sel, exp, i / bc, i), 32'(pin_tx(sel)), 32'(bits[i / bc]));
      if (i == bc / 2) check_eq($sformatf("s%0d_%02h_busy", sel, exp), 32'(pin_busy(sel)), 32'd1);
      if (i == 10 * bc - 1) check_eq($sformatf("s%0d_%02h_done_early", sel, exp), 32'(pin_done(sel)), 32'd0);
      @(negedge clk);
    end
    check_eq($sformatf("s%0d_%02h_done", sel, exp), 32'(pin_done(sel)), 32'd1);
  endtask

  task automatic b2b(input int sel, input logic [7:0] a, input logic [7:0] b, input int bc);
    int w1, w2;
    send(sel, a, 1'b0);
    fork
      begin
        check_frame(sel, a, bc, w1);
        check_frame(sel, b, bc, w2);
        check_eq($sformatf("s%0d_b2b_gap", sel), 32'(w2), 32'd0);
      end
      begin
        send(sel, b, 1'b0);
        check_eq($sformatf("s%0d_b2b_ready_low", sel), 32'(pin_ready(sel)), 32'd0);
      end
    join
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    rst = 1'b0;
    drive(0, 1'b0, 8'h00);
    drive(1, 1'b0, 8'h00);
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check_eq($sformatf("s%0d_rst_tx", s),    32'(pin_tx(s)),    32'd1);
      check_eq($sformatf("s%0d_rst_ready", s), 32'(pin_ready(s)), 32'd1);
      check_eq($sformatf("s%0d_rst_busy", s),  32'(pin_busy(s)),  32'd0);
      check_eq($sformatf("s%0d_rst_done", s),  32'(pin_done(s)),  32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Single byte with accept-to-start latency
    send(0, 8'hA5, 1'b0);
    check_eq("lat_tx_high", 32'(tx0), 32'd1);
    check_eq("lat_ready_low", 32'(rdy0), 32'd0);
    check_frame(0, 8'hA5, 104, w);
    check_eq("lat_wait", 32'(w), 32'd1);
    check_eq("a5_busy_end", 32'(busy0), 32'd0);
    @(negedge clk);
    check_eq("a5_done_once", 32'(done0), 32'd0);
    check_eq("a5_tx_idle", 32'(tx0), 32'd1);

    // Back-to-back frames
    b2b(0, 8'h00, 8'hFF, 104);

    // Backpressure: valid held high across three bytes
    fork
      begin
        check_frame(0, 8'h11, 104, w);
        check_frame(0, 8'h22, 104, w);
        check_frame(0, 8'h33, 104, w);
      end
      begin
        send(0, 8'h11, 1'b1);
        send(0, 8'h22, 1'b1);
        send(0, 8'h33, 1'b0);
      end
    join
    repeat (300) @(negedge clk);
    check_eq("bp_no_extra_tx", 32'(tx0), 32'd1);
    check_eq("bp_no_extra_busy", 32'(busy0), 32'd0);

    // Reset during data bit 3 with a byte waiting in the holding register
    send(0, 8'h5A, 1'b0);
    wait_fall(0, w);
    send(0, 8'h99, 1'b0);
    repeat (4 * 104 + 52 - 1) @(negedge clk);
    check_eq("mid_bit3", 32'(tx0), 32'd1);
    check_eq("mid_busy", 32'(busy0), 32'd1);
    check_eq("mid_hold_full", 32'(rdy0), 32'd0);
    rst = 1'b0;
    #1;
    check_eq("mid_rst_tx", 32'(tx0), 32'd1);
    check_eq("mid_rst_busy", 32'(busy0), 32'd0);
    check_eq("mid_rst_ready", 32'(rdy0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("post_rst_tx", 32'(tx0), 32'd1);
    check_eq("post_rst_busy", 32'(busy0), 32'd0);
    send(0, 8'hC3, 1'b0);
    check_frame(0, 8'hC3, 104, w);

    // Receiver-model loopback patterns
    begin
      logic [7:0] pat [4];
      pat = '{8'h00, 8'h55, 8'hAA, 8'hFF};
      for (int k = 0; k < 4; k++) begin
        send(0, pat[k], 1'b0);
        check_frame(0, pat[k], 104, w);
      end
    end

    // BIT_CYCLES = 2 corner
    send(1, 8'h96, 1'b0);
    check_frame(1, 8'h96, 2, w);
    check_eq("fast_lat_wait", 32'(w), 32'd1);
    @(negedge clk);
    check_eq("fast_done_once", 32'(done1), 32'd0);
    repeat (5) @(negedge clk);
    b2b(1, 8'h3C, 8'hC3, 2);
    repeat (5) @(negedge clk);
    check_eq("fast_idle_busy", 32'(busy1), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
